// File: rtl/lcd_timing_gen.sv
// 480x272 RGB LCD timing generator: pixel clock divider, sync/DE timing, one-pixel request pipeline.
// Define LCD_TESTPATTERN_EN to replace pix_data with 8 vertical colour bars.
module lcd_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pix_data,
    output logic        req_valid,
    output logic [8:0]  req_x,
    output logic [8:0]  req_y,
    output logic        frame_start,
    output logic        lcd_clk,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] D_MAX   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF  = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          run_q, run_d;
    logic          clk_q, clk_d;
    logic          req_valid_q, req_valid_d;
    logic [8:0]    req_x_q, req_x_d, req_y_q, req_y_d;
    logic          fs_q, fs_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [15:0]   rgb_q, rgb_d;
    logic [15:0]   pix_src;
    logic          pix_ce;

`ifdef LCD_TESTPATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    logic [2:0] bar;
    logic       unused_pix;
    assign unused_pix = ^pix_data;

    always_comb begin
        bar = 3'd7;
        if (req_x_q < 9'(BAR_W * 8)) bar = 3'(req_x_q / 9'(BAR_W));
        unique case (bar)
            3'd0: pix_src = 16'hFFFF;
            3'd1: pix_src = 16'hFFE0;
            3'd2: pix_src = 16'h07FF;
            3'd3: pix_src = 16'h07E0;
            3'd4: pix_src = 16'hF81F;
            3'd5: pix_src = 16'hF800;
            3'd6: pix_src = 16'h001F;
            3'd7: pix_src = 16'h0000;
        endcase
    end
`else
    assign pix_src = pix_data;
`endif

    assign pix_ce = (dcnt_q == D_MAX);

    always_comb begin
        dcnt_d      = dcnt_q;
        h_d         = h_q;
        v_d         = v_q;
        run_d       = run_q;
        clk_d       = clk_q;
        req_valid_d = req_valid_q;
        req_x_d     = req_x_q;
        req_y_d     = req_y_q;
        fs_d        = 1'b0;
        de_d        = de_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        rgb_d       = rgb_q;
        if (!en) begin
            dcnt_d      = '0;
            h_d         = '0;
            v_d         = '0;
            run_d       = 1'b0;
            clk_d       = 1'b0;
            req_valid_d = 1'b0;
            req_x_d     = '0;
            req_y_d     = '0;
            de_d        = 1'b0;
            hs_d        = 1'b1;
            vs_d        = 1'b1;
            rgb_d       = '0;
        end else begin
            dcnt_d = pix_ce ? '0 : dcnt_q + 1'b1;
            clk_d  = (dcnt_d >= D_HALF);
            if (pix_ce) begin
                // Panel stage consumes the request made one pixel earlier
                de_d  = req_valid_q;
                hs_d  = !(run_q && h_q >= HS_BEG && h_q < HS_END);
                vs_d  = !(run_q && v_q >= VS_BEG && v_q < VS_END);
                rgb_d = req_valid_q ? pix_src : 16'h0000;
                // First pixel after reset/enable is (0,0) itself, not its successor
                if (run_q) begin
                    if (h_q == H_MAX) begin
                        h_d = '0;
                        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
                run_d       = 1'b1;
                fs_d        = (h_d == '0) && (v_d == '0);
                req_valid_d = (h_d < H_ACT) && (v_d < V_ACT);
                if (req_valid_d) begin
                    req_x_d = 9'(h_d);
                    req_y_d = 9'(v_d);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q      <= '0;
            h_q         <= '0;
            v_q         <= '0;
            run_q       <= 1'b0;
            clk_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_x_q     <= '0;
            req_y_q     <= '0;
            fs_q        <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            rgb_q       <= '0;
        end else begin
            dcnt_q      <= dcnt_d;
            h_q         <= h_d;
            v_q         <= v_d;
            run_q       <= run_d;
            clk_q       <= clk_d;
            req_valid_q <= req_valid_d;
            req_x_q     <= req_x_d;
            req_y_q     <= req_y_d;
            fs_q        <= fs_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign frame_start = fs_q;
    assign lcd_clk     = clk_q;
    assign lcd_de      = de_q;
    assign lcd_hsync   = hs_q;
    assign lcd_vsync   = vs_q;
    assign lcd_r       = rgb_q[15:11];
    assign lcd_g       = rgb_q[10:5];
    assign lcd_b       = rgb_q[4:0];
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a shrunken 48x12 raster (57x19 total, CLK_DIV=2).
// Builds with or without LCD_TESTPATTERN_EN; pixel expectations follow the build.
module tb_lcd_timing_gen;
    localparam int H_ACT = 48, H_FP = 2, H_SY = 5, H_BP = 2;
    localparam int V_ACT = 12, V_FP = 2, V_SY = 3, V_BP = 2;
    localparam int H_TOT = 57;          // 48+2+5+2
    localparam int V_TOT = 19;          // 12+2+3+2
    localparam int FRAME_CLK = 2166;    // 57*19*2
    localparam logic [39:0] IDLE = 40'h30_0000_0000; // hsync=vsync=1, all else 0

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] pix_data;
    logic        req_valid, frame_start, lcd_clk, lcd_de, lcd_hsync, lcd_vsync;
    logic [8:0]  req_x, req_y;
    logic [4:0]  lcd_r, lcd_b;
    logic [5:0]  lcd_g;

    int checks = 0;
    int failures = 0;

    lcd_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
        .lcd_clk(lcd_clk), .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
    );

    always #5 clk = ~clk;

    // Behavioural pixel source
    always_comb pix_data = {req_x[4:0], req_y[5:0], 5'd0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] bundle();
        return {lcd_clk, lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b,
                req_valid, req_x, req_y, frame_start};
    endfunction

    function automatic logic [15:0] exp_pix(input int col, input int line);
        logic [8:0] cx, ly;
        cx = 9'(col);
        ly = 9'(line);
`ifdef LCD_TESTPATTERN_EN
        case (col / 6)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        return {cx[4:0], ly[5:0], 5'd0};
`endif
    endfunction

    // Negedges until frame_start is seen (20 on timeout)
    task automatic fs_latency(output int n);
        n = 20;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (frame_start) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_req(input string tag, input int x, input int y);
        bit hit = 0;
        for (int k = 0; k < 3 * FRAME_CLK; k++) begin
            @(negedge clk);
            if (req_valid && req_x == 9'(x) && req_y == 9'(y)) begin
                hit = 1;
                break;
            end
        end
        check_eq(tag, 64'(hit), 64'd1);
    endtask

    initial begin
        int lat, errs, fs_mid, fs_end, de_cnt, hs_cnt, vs_cnt, rv_cnt;
        int de_first, hs_first, vs_first, de_run;
        logic [15:0] cap_pix;
        logic [17:0] cap_req;
`ifdef LCD_TESTPATTERN_EN
        logic [15:0] tp0, tp6, tp47;
`endif

        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_idle", 64'(bundle()), 64'(IDLE));
        rst = 1'b0;

        fs_latency(lat);
        check_eq("fs_latency_reset", 64'(lat), 64'd2);
        check_eq("first_req", 64'({req_valid, req_x, req_y}), 64'({1'b1, 18'd0}));

        // One full frame, index 0 = the frame_start sample
        errs = 0; fs_mid = 0; fs_end = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; rv_cnt = 0;
        de_first = -1; hs_first = -1; vs_first = -1; de_run = 0;
        cap_pix = '0; cap_req = '0;
`ifdef LCD_TESTPATTERN_EN
        tp0 = '1; tp6 = '1; tp47 = '1;
`endif
        for (int i = 1; i <= FRAME_CLK; i++) begin
            @(negedge clk);
            if (frame_start) begin
                if (i == FRAME_CLK) fs_end++;
                else fs_mid++;
            end
            if (lcd_de) de_cnt++;
            if (!lcd_hsync) hs_cnt++;
            if (!lcd_vsync) vs_cnt++;
            if (req_valid) rv_cnt++;
            if (lcd_de && de_first < 0) de_first = i;
            if (!lcd_hsync && hs_first < 0) hs_first = i;
            if (!lcd_vsync && vs_first < 0) vs_first = i;
            if (lcd_de && i < 114) de_run++;
            if (lcd_clk !== i[0]) errs++;
            if (i >= 2) begin
                int p, col, line;
                logic de_e, hs_e, vs_e;
                logic [15:0] rgb_e;
                p = (i - 2) / 2;
                col = p % H_TOT;
                line = p / H_TOT;
                de_e = (col < H_ACT) && (line < V_ACT);
                hs_e = !(col >= 50 && col < 55);
                vs_e = !(line >= 14 && line < 17);
                rgb_e = de_e ? exp_pix(col, line) : 16'h0000;
                if ({lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b} !== {de_e, hs_e, vs_e, rgb_e})
                    errs++;
            end
            if (i == 1214) cap_req = {req_x, req_y};
            if (i == 1216) cap_pix = {lcd_r, lcd_g, lcd_b};
`ifdef LCD_TESTPATTERN_EN
            if (i == 2)  tp0  = {lcd_r, lcd_g, lcd_b};
            if (i == 14) tp6  = {lcd_r, lcd_g, lcd_b};
            if (i == 96) tp47 = {lcd_r, lcd_g, lcd_b};
`endif
        end
        check_eq("frame_period", 64'(fs_end), 64'd1);
        check_eq("fs_extra", 64'(fs_mid), 64'd0);
        check_eq("frame_samples", 64'(errs), 64'd0);
        check_eq("de_count", 64'(de_cnt), 64'd1152);
        check_eq("rv_count", 64'(rv_cnt), 64'd1152);
        check_eq("hs_count", 64'(hs_cnt), 64'd190);
        check_eq("vs_count", 64'(vs_cnt), 64'd342);
        check_eq("de_first", 64'(de_first), 64'd2);
        check_eq("de_run_line0", 64'(de_run), 64'd96);
        check_eq("hs_first", 64'(hs_first), 64'd102);
        check_eq("vs_first", 64'(vs_first), 64'd1598);
        check_eq("req_37_10", 64'(cap_req), 64'({9'd37, 9'd10}));
`ifdef LCD_TESTPATTERN_EN
        check_eq("tp_pix0", 64'(tp0), 64'h FFFF);
        check_eq("tp_pix6", 64'(tp6), 64'h FFE0);
        check_eq("tp_pix47", 64'(tp47), 64'h0000);
`else
        check_eq("pix_37_10", 64'(cap_pix), 64'({5'd5, 6'd10, 5'd0}));
`endif

        // Asynchronous reset mid-frame
        wait_req("wait_mid_frame", 20, 7);
        rst = 1'b1;
        #1;
        check_eq("rst_async_idle", 64'(bundle()), 64'(IDLE));
        repeat (3) @(negedge clk);
        check_eq("rst_held_idle", 64'(bundle()), 64'(IDLE));
        rst = 1'b0;
        fs_latency(lat);
        check_eq("fs_latency_rerst", 64'(lat), 64'd2);
        check_eq("req_after_rst", 64'({req_valid, req_x, req_y}), 64'({1'b1, 18'd0}));

        // Enable dropped mid-line for 10 clk
        wait_req("wait_mid_line", 30, 2);
        en = 1'b0;
        @(negedge clk);
        check_eq("en_low_idle", 64'(bundle()), 64'(IDLE));
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bundle() !== IDLE) errs++;
        end
        check_eq("en_low_hold", 64'(errs), 64'd0);
        en = 1'b1;
        fs_latency(lat);
        check_eq("fs_latency_en", 64'(lat), 64'd2);
        check_eq("req_after_en", 64'({req_valid, req_x, req_y}), 64'({1'b1, 18'd0}));
        repeat (2) @(negedge clk);
        check_eq("de_after_en", 64'({lcd_de, lcd_r, lcd_g, lcd_b}), 64'({1'b1, exp_pix(0, 0)}));
        @(negedge clk);
        check_eq("req_x1_after_en", 64'({req_valid, req_x, req_y}), 64'({1'b1, 9'd1, 9'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Drives the on-board 480x272 RGB LCD directly from the board crystal clock.
- Generates the pixel clock, HSYNC/VSYNC/DE timing, and a pixel-coordinate request one pixel period ahead.
- Registers the upstream RGB565 pixel data onto the panel bus.
- Sits between the top level's clock/reset and the LCD_* pins; an upstream pixel source consumes req_x/req_y and returns pix_data.

Parameters:
- CLK_DIV, 2: clk cycles per pixel clock; even, >=2.
- H_ACTIVE, 480: visible pixels per line.
- H_FP, 2: horizontal front porch in pixels.
- H_SYNC, 41: HSYNC width in pixels.
- H_BP, 2: horizontal back porch in pixels.
- V_ACTIVE, 272: visible lines per frame.
- V_FP, 2: vertical front porch in lines.
- V_SYNC, 10: VSYNC width in lines.
- V_BP, 2: vertical back porch in lines.

Ports:
- clk  in  1  system clock (crystal, 24 MHz).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low = hold idle.
- pix_data  in  16  RGB565 pixel for the last requested coordinate.
- req_valid  out  1  req_x/req_y are a visible pixel to fetch.
- req_x  out  9  requested column, 0..H_ACTIVE-1.
- req_y  out  9  requested row, 0..V_ACTIVE-1.
- frame_start  out  1  one-clk pulse at h=0, v=0.
- lcd_clk  out  1  panel pixel clock.
- lcd_de  out  1  data enable.
- lcd_hsync  out  1  HSYNC, active low.
- lcd_vsync  out  1  VSYNC, active low.
- lcd_r  out  5  red.
- lcd_g  out  6  green.
- lcd_b  out  5  blue.

Behaviour:
- Reset: applies asynchronously and forces every output to its idle value.
  - lcd_clk=0, lcd_de=0, lcd_hsync=1, lcd_vsync=1, lcd_r/g/b=0.
  - req_valid=0, req_x=req_y=0, frame_start=0.
  - Internal counters dcnt=0, h=0, v=0.
- Divider: dcnt counts 0..CLK_DIV-1 and wraps.
  - lcd_clk is registered and equals 1 while dcnt >= CLK_DIV/2.
  - pix_ce = (dcnt == CLK_DIV-1). All timing and panel outputs update only on pix_ce cycles, so they change together with the lcd_clk falling edge; the panel samples on the rising edge.
- Counters: h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - On h wrap, v increments; v runs 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both wrap to 0 together at end of frame.
- Line regions, in order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical regions follow the same order on v.
- Pipeline, two stages each one pixel period:
  - Stage 1 (request): on the pix_ce cycle where the counters move to (h,v), drive req_x=h, req_y=v and req_valid=(h<H_ACTIVE && v<V_ACTIVE). When invisible, req_x/req_y hold their last values.
  - Upstream must present pix_data for that request no later than the next pix_ce cycle.
  - Stage 2 (panel): on the next pix_ce, drive lcd_de = the previous req_valid. Drive lcd_hsync/lcd_vsync from the previous (h,v) sync regions.
  - Pixel bus: lcd_r=pix_data[15:11], lcd_g=pix_data[10:5], lcd_b=pix_data[4:0] when DE is set, else 0.
  - Latency: exactly one pixel period (CLK_DIV clk cycles) from request to panel. Syncs are delayed identically, so DE/HSYNC/VSYNC stay mutually aligned.
- frame_start: a single clk-cycle pulse on the pix_ce cycle where the counters become (0,0). It is a request-stage event.
- en low:
  - dcnt, h and v are forced to 0 on the next clk; lcd_clk holds 0.
  - Panel outputs return to idle (as reset) on that clk.
  - Restart begins at (0,0) with frame_start.
- rst asserted mid-line or mid-frame: immediate idle with no partial completion. The first frame after release starts at (0,0).

Optional Feature:
- Macro: LCD_TESTPATTERN_EN.
- Defined: pix_data is ignored. The panel shows 8 vertical colour bars, each H_ACTIVE/8 = 60 px wide, in the order white, yellow, cyan, green, magenta, red, blue, black (full-scale components; white = 16'hFFFF). Bar index is derived from the request-stage req_x and registered with the same one-pixel latency. Timing is unchanged.
- Not defined: pixel data comes from pix_data as above.

Test Plan:
- Release rst with en=1, CLK_DIV=2 -> lcd_clk toggles every clk cycle. One line = 525 pixel periods = 1050 clk. One frame = 286 lines = 300300 clk. frame_start pulses exactly once per frame.
- Across one line -> lcd_de high for exactly 480 consecutive pixel clocks starting one pixel after req_valid rises. lcd_hsync low for 41 pixels starting 482 pixels after DE rises.
- pix_data = {req_x[4:0], req_y[5:0], 5'd0} from a behavioural source -> the panel shows pixel (37,100) with lcd_r=5, lcd_g=36, lcd_b=0, aligned to the 38th DE pixel of line 100.
- Assert rst mid-frame at v=150, h=200 -> all outputs idle in the same cycle. After release, frame_start is seen within 2 clk of the first pix_ce.
- Deassert en for 10 clk mid-line -> outputs idle and lcd_clk=0. After re-enable, timing restarts at (0,0) with frame_start.
- With LCD_TESTPATTERN_EN defined -> DE pixel 0 = 16'hFFFF, pixel 60 = 16'hFFE0, pixel 479 = 16'h0000, regardless of pix_data.
